// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer for the single-cycle CPU core.
// Sole driver of the core enable; also keeps retire/control-flow statistics.
module cpu_run_ctrl #(
   parameter int CNT_WIDTH  = 32,
   parameter int STEP_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run_req,
   input  logic                  step_req,
   input  logic [STEP_WIDTH-1:0] step_n,
   input  logic                  stop_req,
   input  logic                  bp_en,
   input  logic [31:0]           bp_addr,
   input  logic                  clr_cnt,
   input  logic [31:0]           cpu_pc,
   input  logic                  cpu_halt,
   input  logic                  cpu_is_jump,
   input  logic                  cpu_is_branch,
   input  logic                  cpu_branched,
   output logic                  cpu_en,
   output logic [1:0]            state,
   output logic                  bp_hit,
   output logic [CNT_WIDTH-1:0]  inst_cnt,
   output logic [CNT_WIDTH-1:0]  jump_cnt,
   output logic [CNT_WIDTH-1:0]  branch_cnt,
   output logic [CNT_WIDTH-1:0]  taken_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_STEP = 2'd2,
      S_HALT = 2'd3
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [STEP_WIDTH-1:0] r_step_left, w_step_left_nxt;
   logic                  r_skip_bp, w_skip_bp_nxt;
   logic                  r_bp_hit, w_bp_hit_nxt;
   logic                  w_bp_match;
   logic                  w_en;
   logic [STEP_WIDTH-1:0] w_step_init;
   logic [CNT_WIDTH-1:0]  r_inst_cnt, r_jump_cnt, r_branch_cnt, r_taken_cnt;

   assign w_bp_match  = bp_en & (cpu_pc == bp_addr) & ~r_skip_bp;
   assign w_step_init = (step_n == '0) ? STEP_WIDTH'(1) : step_n;

   // Enable is held low while reset is asserted so the core never advances in that cycle.
   always_comb begin
      w_en = 1'b0;
      if (!rst && !cpu_halt) begin
         if (r_state == S_RUN)
            w_en = ~w_bp_match;
         else if (r_state == S_STEP)
            w_en = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_step_left_nxt = r_step_left;
      w_skip_bp_nxt   = r_skip_bp;
      w_bp_hit_nxt    = r_bp_hit;
      case (r_state)
         S_IDLE: begin
            if (cpu_halt) begin
               w_state_nxt = S_HALT;
            end else if (run_req) begin
               w_state_nxt   = S_RUN;
               w_skip_bp_nxt = 1'b1;
               w_bp_hit_nxt  = 1'b0;
            end else if (step_req) begin
               w_state_nxt     = S_STEP;
               w_step_left_nxt = w_step_init;
               w_bp_hit_nxt    = 1'b0;
            end
         end
         S_RUN: begin
            // Leaving a breakpoint: the first retired instruction re-arms matching.
            if (w_en)
               w_skip_bp_nxt = 1'b0;
            if (cpu_halt) begin
               w_state_nxt = S_HALT;
            end else if (stop_req) begin
               w_state_nxt = S_IDLE;
            end else if (w_bp_match) begin
               w_state_nxt  = S_IDLE;
               w_bp_hit_nxt = 1'b1;
            end
         end
         S_STEP: begin
            if (cpu_halt) begin
               w_state_nxt = S_HALT;
            end else if (stop_req) begin
               w_state_nxt = S_IDLE;
            end else if (w_en) begin
               w_step_left_nxt = r_step_left - STEP_WIDTH'(1);
               if (r_step_left == STEP_WIDTH'(1))
                  w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_step_left <= '0;
         r_skip_bp   <= 1'b0;
         r_bp_hit    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_step_left <= w_step_left_nxt;
         r_skip_bp   <= w_skip_bp_nxt;
         r_bp_hit    <= w_bp_hit_nxt;
      end
   end

   // Statistics: clear wins over a same-cycle retire.
   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         r_inst_cnt   <= '0;
         r_jump_cnt   <= '0;
         r_branch_cnt <= '0;
         r_taken_cnt  <= '0;
      end else if (w_en) begin
         r_inst_cnt <= r_inst_cnt + CNT_WIDTH'(1);
         if (cpu_is_jump)
            r_jump_cnt <= r_jump_cnt + CNT_WIDTH'(1);
         if (cpu_is_branch)
            r_branch_cnt <= r_branch_cnt + CNT_WIDTH'(1);
         if (cpu_branched)
            r_taken_cnt <= r_taken_cnt + CNT_WIDTH'(1);
      end
   end

   assign cpu_en     = w_en;
   assign state      = r_state;
   assign bp_hit     = r_bp_hit;
   assign inst_cnt   = r_inst_cnt;
   assign jump_cnt   = r_jump_cnt;
   assign branch_cnt = r_branch_cnt;
   assign taken_cnt  = r_taken_cnt;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run/step/breakpoint sequencer for the single-cycle CPU core; sole driver of the core's en input.
- Tracks execution state (idle, run, step-N, halted) from host/debug requests and core status (pc_dbg, halt, is_jump, is_branch, branched).
- Keeps retired-instruction and control-flow statistics counters for the display/debug path.

Parameters:
CNT_WIDTH, 32, width of all statistics counters
STEP_WIDTH, 16, width of the step-count request

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
run_req  in  1  one-cycle pulse: free-run request
step_req  in  1  one-cycle pulse: execute step_n instructions
step_n  in  STEP_WIDTH  instructions per step request; 0 is treated as 1
stop_req  in  1  one-cycle pulse: return to IDLE
bp_en  in  1  breakpoint enable
bp_addr  in  32  breakpoint byte address, compared to cpu_pc
clr_cnt  in  1  synchronous clear of all statistics counters
cpu_pc  in  32  core pc_dbg
cpu_halt  in  1  core halt (level)
cpu_is_jump  in  1  core is_jump
cpu_is_branch  in  1  core is_branch
cpu_branched  in  1  core branched
cpu_en  out  1  core enable, combinational from state and inputs
state  out  2  0=IDLE 1=RUN 2=STEP 3=HALT
bp_hit  out  1  registered, set when RUN stopped on breakpoint
inst_cnt  out  CNT_WIDTH  instructions retired (cycles with cpu_en=1)
jump_cnt  out  CNT_WIDTH  retired jumps
branch_cnt  out  CNT_WIDTH  retired branches
taken_cnt  out  CNT_WIDTH  retired taken branches

Behaviour:
- Reset (rst=1 at edge): state=IDLE, step_left=0, skip_bp=0, bp_hit=0, all counters 0; cpu_en=0 during and after reset cycle.
- bp_match = bp_en & (cpu_pc==bp_addr) & ~skip_bp.
- cpu_en = ~cpu_halt & ((state==RUN & ~bp_match) | state==STEP). Always 0 in IDLE/HALT.
- One instruction retires per cycle with cpu_en=1; counters increment on those cycles only: inst_cnt by 1; jump/branch/taken_cnt by 1 when respective core flag is 1. Counters wrap modulo 2^CNT_WIDTH. clr_cnt wins over same-cycle increment (result 0).
- IDLE: cpu_halt -> HALT; else run_req -> RUN (skip_bp=1, bp_hit=0); else step_req -> STEP (step_left=max(step_n,1), bp_hit=0). run_req beats step_req. stop_req ignored.
- RUN: cpu_halt -> HALT; else stop_req -> IDLE (instruction in this cycle still retires if cpu_en=1); else bp_match -> IDLE, bp_hit=1, no retire. skip_bp clears on first retired cycle, so resuming from a breakpoint executes the breakpointed instruction. run_req/step_req ignored.
- STEP: breakpoints not checked. cpu_halt -> HALT. stop_req -> IDLE. Each retired cycle decrements step_left; retire with step_left==1 -> IDLE. Exactly max(step_n,1) instructions retire absent halt/stop. New requests ignored.
- HALT: terminal, cpu_en=0, counters frozen (clr_cnt still clears); exit only via rst.
- Priority within a state: rst > cpu_halt > stop_req > bp_match/step completion.
- rst mid-RUN/STEP: next cycle IDLE, cpu_en=0, counters 0.

Test Plan:
- Reset, run_req pulse, cpu_halt rises after 10 enabled cycles -> cpu_en high exactly 10 cycles, state=3, inst_cnt=10.
- step_req with step_n=3 -> cpu_en high 3 consecutive cycles, state 2 then 0, inst_cnt=3; step_n=0 -> exactly 1 cycle.
- bp_en=1, bp_addr=0x10, cpu_pc advancing by 4 from 0 under RUN -> cpu_en drops when cpu_pc=0x10, state=0, bp_hit=1, inst_cnt=4; next run_req retires 0x10 instruction without re-stopping.
- RUN with cpu_is_jump on 2 cycles, cpu_is_branch on 3, cpu_branched on 1 -> jump_cnt=2, branch_cnt=3, taken_cnt=1; flags asserted while cpu_en=0 are not counted.
- stop_req during STEP step_n=100 after 5 retires -> IDLE, inst_cnt=6 (stop-cycle retires); clr_cnt with increment same cycle -> inst_cnt=0.
- run_req and step_req same cycle -> state=1; rst mid-RUN -> state=0, all counters 0, cpu_en=0 next cycle.
